serial_par: RTL and testbench

Serial-to-parallel receive stage running at 32x the word rate. It deserialises a 1-bit line, MSB first, into bytes. It acquires byte alignment from the 0xBC idle/comma character and presents data bytes with a valid flag. It sits directly upstream of the 8-to-32 converter, which consumes `out_data`/`out` as its `in_data`/`in` pair.

---
 rtl/serial_par.sv | 159 +++++++++++++++
 tb/tb_serial_par.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_par.sv
// -----------------------------------------------------------------------------
// serial_par
//
// Serial-to-parallel receive stage running at 32x the word rate. A 1-bit line
// is deserialised MSB first into bytes. Byte alignment is acquired from a run
// of LOCK_COUNT consecutive COMMA characters. Once locked, every byte boundary
// presents the received byte on out_data. The valid flag out is set for data
// bytes and cleared for commas.
//
// Parameters
//   COMMA       idle/alignment character (default 8'hBC)
//   LOCK_COUNT  consecutive aligned commas needed for lock, 2..7 (default 4)
//
// Ports
//   clk_32f   in   bit clock, one serial bit per rising edge
//   reset     in   synchronous, active-high reset
//   data_in   in   serial line, MSB of each byte first
//   out_data  out  [7:0] last completed byte (registered)
//   out       out  out_data is a data byte and the block is locked
//   active    out  high while the receiver is locked
//
// Build option
//   SERIAL_PAR_BIT_ALIGN_EN  when defined, SEARCH compares against COMMA on
//                            every bit and re-phases the byte counter on a
//                            hit, which recovers an arbitrary bit offset.
//                            When undefined, byte phase is fixed by reset
//                            release.
// -----------------------------------------------------------------------------
module serial_par #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] out_data,
    output logic       out,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_CNT3 = 3'(LOCK_COUNT);

    state_t     state, state_nxt;
    logic [6:0] sh;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [2:0] bc_cnt,  bc_cnt_nxt;
    logic [2:0] bc_inc;
    logic [7:0] win;
    logic [7:0] out_data_nxt;
    logic       out_nxt;
    logic       active_nxt;
    logic       boundary;
    logic       is_comma;

    // Candidate byte includes the bit arriving this cycle.
    assign win      = {sh, data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign is_comma = (win == COMMA);
    assign bc_inc   = bc_cnt + 3'd1;

    // State and datapath registers.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so the order of statements here does not matter.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state    <= SEARCH;
            sh       <= '0;
            bit_cnt  <= '0;
            bc_cnt   <= '0;
            out_data <= '0;
            out      <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sh       <= win[6:0];
            bit_cnt  <= bit_cnt_nxt;
            bc_cnt   <= bc_cnt_nxt;
            out_data <= out_data_nxt;
            out      <= out_nxt;
            active   <= active_nxt;
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        bc_cnt_nxt  = bc_cnt;
        bit_cnt_nxt = bit_cnt + 3'd1;

        unique case (state)
            SEARCH: begin
`ifdef SERIAL_PAR_BIT_ALIGN_EN
                // Hunt on every bit; a hit makes the next boundary land
                // exactly 8 cycles later.
                if (is_comma) begin
                    state_nxt   = COUNT;
                    bc_cnt_nxt  = 3'd1;
                    bit_cnt_nxt = 3'd0;
                end
`else
                if (boundary && is_comma) begin
                    state_nxt  = COUNT;
                    bc_cnt_nxt = 3'd1;
                end
`endif
            end

            COUNT: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_nxt = bc_inc;
                        if (bc_inc == LOCK_CNT3) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        state_nxt  = SEARCH;
                        bc_cnt_nxt = 3'd0;
                    end
                end
            end

            LOCKED: begin
                // Only reset leaves LOCKED.
            end

            default: begin
                state_nxt  = SEARCH;
                bc_cnt_nxt = 3'd0;
            end
        endcase
    end

    // Next-output logic. Outputs are registered, so active rises on the same
    // edge that moves the state register into LOCKED, and the lock-completing
    // comma never reaches out_data.
    always_comb begin
        out_data_nxt = 8'h00;
        out_nxt      = 1'b0;
        active_nxt   = (state_nxt == LOCKED);

        if (state == LOCKED) begin
            out_data_nxt = out_data;
            out_nxt      = out;
            if (boundary) begin
                out_data_nxt = win;
                out_nxt      = !is_comma;
            end
        end
    end

endmodule

// File: tb/tb_serial_par.sv
// -----------------------------------------------------------------------------
// tb_serial_par
//
// Directed and randomised stimulus for serial_par. A byte-level reference
// model tracks the bit stream since reset. It assembles the receive window
// and applies the comma-run and lock rules once per byte slot. Outputs are
// compared on the falling edge after every bit. Directed checks cover lock
// timing, relock after a broken run, mid-byte reset, a comma inside data, and
// a stream with a 3-bit offset.
// -----------------------------------------------------------------------------
module tb_serial_par;

    localparam logic [7:0] COMMA      = 8'hBC;
    localparam int         LOCK_COUNT = 4;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] out_data;
    logic       valid;
    logic       active;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model state: byte history, byte-slot phase, comma run length.
    logic [7:0] m_hist;
    logic [7:0] m_od;
    logic       m_ov;
    logic       m_locked;
    int         m_run;
    int         m_phase;

    serial_par #(
        .COMMA      (COMMA),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .out_data (out_data),
        .out      (valid),
        .active   (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        logic [7:0] w;
        if (r) begin
            m_hist   = 8'h00;
            m_od     = 8'h00;
            m_ov     = 1'b0;
            m_locked = 1'b0;
            m_run    = 0;
            m_phase  = 0;
            return;
        end
        w      = {m_hist[6:0], b};
        m_hist = w;
`ifdef SERIAL_PAR_BIT_ALIGN_EN
        // While hunting, any bit position may start a comma run.
        if (!m_locked && m_run == 0 && w == COMMA) begin
            m_run   = 1;
            m_phase = 0;
            return;
        end
`endif
        if (m_phase == 7) begin
            if (m_locked) begin
                m_od = w;
                m_ov = (w != COMMA);
            end else if (w == COMMA) begin
                m_run++;
                if (m_run == LOCK_COUNT) m_locked = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        m_phase = (m_phase + 1) % 8;
    endtask

    // One bit time: drive, clock, advance the model, compare on the falling edge.
    task automatic step(input logic b, input logic r);
        data_in = b;
        reset   = r;
        @(posedge clk_32f);
        model_step(b, r);
        @(negedge clk_32f);
        check("out_data", out_data, m_od);
        check("out", {7'd0, valid}, {7'd0, m_ov});
        check("active", {7'd0, active}, {7'd0, m_locked});
    endtask

    // Send the n most significant bits of v, MSB first.
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) step(v[i], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits(v, 8);
    endtask

    initial begin
        int         lows;
        logic [7:0] rv;

        data_in = 1'b0;
        reset   = 1'b1;

        // Reset for two cycles.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("rst_out_data", out_data, 8'h00);
        check("rst_active", {7'd0, active}, 8'h00);

        // Aligned lock then data: lock lands exactly on bit 31.
        for (int k = 0; k < 3; k++) send_byte(COMMA);
        send_bits(COMMA, 7);
        check("t1_pre_lock_active", {7'd0, active}, 8'h00);
        step(COMMA[0], 1'b0);
        check("t1_lock_active", {7'd0, active}, 8'h01);
        check("t1_lock_out", {7'd0, valid}, 8'h00);
        check("t1_lock_out_data", out_data, 8'h00);
        send_byte(8'h12);
        check("t1_d12", out_data, 8'h12);
        check("t1_d12_out", {7'd0, valid}, 8'h01);
        send_byte(8'h34);
        check("t1_d34", out_data, 8'h34);
        send_byte(COMMA);
        check("t1_idle_out", {7'd0, valid}, 8'h00);
        send_byte(8'hFF);
        check("t1_dFF", out_data, 8'hFF);
        check("t1_dFF_out", {7'd0, valid}, 8'h01);

        // A broken comma run sends the block back to SEARCH.
        step(1'b0, 1'b1);
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(8'h55);
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(COMMA);
        check("t2_no_lock_yet", {7'd0, active}, 8'h00);
        send_byte(COMMA);
        check("t2_lock", {7'd0, active}, 8'h01);
        check("t2_lock_out", {7'd0, valid}, 8'h00);
        send_byte(8'hA0);
        check("t2_dA0", out_data, 8'hA0);
        check("t2_dA0_out", {7'd0, valid}, 8'h01);

        // Mid-byte reset while locked, then a fresh four-comma relock.
        send_byte(8'h01);
        send_bits(8'h77, 3);
        step(1'b0, 1'b1);
        check("t3_rst_out_data", out_data, 8'h00);
        check("t3_rst_out", {7'd0, valid}, 8'h00);
        check("t3_rst_active", {7'd0, active}, 8'h00);
        for (int k = 0; k < 3; k++) send_byte(COMMA);
        check("t3_three_commas", {7'd0, active}, 8'h00);
        send_byte(COMMA);
        check("t3_relock", {7'd0, active}, 8'h01);

        // A comma between two data bytes drops out for exactly one byte slot.
        send_byte(8'h01);
        check("t5_d01", out_data, 8'h01);
        lows = 0;
        for (int i = 7; i >= 0; i--) begin
            step(COMMA[i], 1'b0);
            if (!valid) lows++;
        end
        rv = 8'h02;
        for (int i = 7; i >= 0; i--) begin
            step(rv[i], 1'b0);
            if (!valid) lows++;
        end
        check("t5_low_cycles", 8'(lows), 8'd8);
        check("t5_d02", out_data, 8'h02);

        // Three garbage bits ahead of the comma run.
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(COMMA);
        send_byte(8'hC3);
`ifdef SERIAL_PAR_BIT_ALIGN_EN
        check("t4_align_active", {7'd0, active}, 8'h01);
        check("t4_align_dC3", out_data, 8'hC3);
        check("t4_align_out", {7'd0, valid}, 8'h01);
`else
        check("t4_offset_active", {7'd0, active}, 8'h00);
        check("t4_offset_out", {7'd0, valid}, 8'h00);
`endif
        for (int k = 0; k < 4; k++) send_byte(8'h00);

        // Randomised locked traffic with frequent idle commas.
        step(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(COMMA);
        for (int k = 0; k < 48; k++) begin
            rv = ($urandom_range(3) == 0) ? COMMA : 8'($urandom);
            send_byte(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
